// File: rtl/aes_key_schedule_streamer.sv
// AES-128/192/256 key expansion into an on-chip word buffer, then streams round keys
// forward (encrypt order) or reversed (decrypt order) over a valid/ready handshake.
module aes_key_schedule_streamer #(
   parameter int unsigned MAX_NK = 8
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         start,
   input  logic         abort,
   input  logic [7:0]   Nk,
   input  logic         decOrder,
   input  logic [255:0] cipherKey,
   output logic         busy,
   output logic [127:0] roundKey,
   output logic         roundKeyValid,
   input  logic         roundKeyReady,
   output logic         roundKeyLast,
   output logic         done,
   output logic         keyError
);

   localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
   localparam int unsigned AW    = $clog2(DEPTH);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] EXPAND = 2'd2;
   localparam logic [1:0] STREAM = 2'd3;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [1:0]    stateQ, stateD;
   logic [3:0]    nkQ, nkD;
   logic          decQ, decD;
   logic [7:0]    rconQ, rconD;
   logic [AW-1:0] idxQ, idxD;
   logic [2:0]    modQ, modD;
   logic [3:0]    rndQ, rndD;
   logic          doneQ, doneD;
   logic          keyErrQ, keyErrD;

   // Key is captured with start so the source may change while LOAD runs.
   logic [255:0]  keyQ;
   logic [31:0]   wordBuf [DEPTH];

   logic          legalNk;
   logic          acceptStart;
   logic [3:0]    nr;
   logic [AW-1:0] lastIdx;
   logic [AW-1:0] rdBase;
   logic [255:0]  alignedKey;
   logic [31:0]   prevWord;
   logic [31:0]   backWord;
   logic [31:0]   temp;
   logic [31:0]   newWord;

   assign legalNk     = (Nk == 8'd4 || Nk == 8'd6 || Nk == 8'd8) && (Nk <= 8'(MAX_NK));
   assign acceptStart = (stateQ == IDLE) && start && !abort && legalNk;
   assign nr          = nkQ + 4'd6;
   assign lastIdx     = AW'({nkQ, 2'b00}) + AW'(27);
   assign rdBase      = AW'({rndQ, 2'b00});

   // Left-justify the key so w[k] always sits at a fixed slice.
   always_comb begin
      case (nkQ)
         4'd4:    alignedKey = {keyQ[127:0], 128'h0};
         4'd6:    alignedKey = {keyQ[191:0], 64'h0};
         default: alignedKey = keyQ;
      endcase
   end

   // modQ tracks i mod Nk as a wrapping counter alongside idxQ.
   always_comb begin
      prevWord = wordBuf[idxQ - AW'(1)];
      backWord = wordBuf[idxQ - AW'(nkQ)];
      temp     = prevWord;
      if (modQ == 3'd0) begin
         temp = subWord({prevWord[23:0], prevWord[31:24]}) ^ {rconQ, 24'h0};
      end else if (nkQ == 4'd8 && modQ == 3'd4) begin
         temp = subWord(prevWord);
      end
      newWord = backWord ^ temp;
   end

   always_comb begin
      stateD  = stateQ;
      nkD     = nkQ;
      decD    = decQ;
      rconD   = rconQ;
      idxD    = idxQ;
      modD    = modQ;
      rndD    = rndQ;
      doneD   = 1'b0;
      keyErrD = 1'b0;
      if (abort) begin
         stateD = IDLE;
      end else begin
         case (stateQ)
            IDLE: begin
               if (start) begin
                  if (legalNk) begin
                     nkD    = Nk[3:0];
                     decD   = decOrder;
                     stateD = LOAD;
                  end else begin
                     keyErrD = 1'b1;
                  end
               end
            end
            LOAD: begin
               rconD  = 8'h01;
               idxD   = AW'(nkQ);
               modD   = 3'd0;
               stateD = EXPAND;
            end
            EXPAND: begin
               idxD = idxQ + AW'(1);
               modD = ({1'b0, modQ} == nkQ - 4'd1) ? 3'd0 : modQ + 3'd1;
               if (modQ == 3'd0) begin
                  rconD = xtime(rconQ);
               end
               if (idxQ == lastIdx) begin
                  stateD = STREAM;
                  rndD   = decQ ? nr : 4'd0;
               end
            end
            STREAM: begin
               if (roundKeyReady) begin
                  if (roundKeyLast) begin
                     stateD = IDLE;
                     doneD  = 1'b1;
                  end else begin
                     rndD = decQ ? rndQ - 4'd1 : rndQ + 4'd1;
                  end
               end
            end
            default: stateD = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         stateQ  <= IDLE;
         nkQ     <= 4'd4;
         decQ    <= 1'b0;
         rconQ   <= 8'h01;
         idxQ    <= '0;
         modQ    <= 3'd0;
         rndQ    <= 4'd0;
         doneQ   <= 1'b0;
         keyErrQ <= 1'b0;
      end else begin
         stateQ  <= stateD;
         nkQ     <= nkD;
         decQ    <= decD;
         rconQ   <= rconD;
         idxQ    <= idxD;
         modQ    <= modD;
         rndQ    <= rndD;
         doneQ   <= doneD;
         keyErrQ <= keyErrD;
      end
   end

   // Buffer and captured key are deliberately not reset.
   always_ff @(posedge clk) begin
      if (acceptStart) begin
         keyQ <= cipherKey;
      end
      if (stateQ == LOAD) begin
         for (int k = 0; k < 8; k++) begin
            if (k < int'(nkQ)) begin
               wordBuf[k] <= alignedKey[255 - 32 * k -: 32];
            end
         end
      end
      if (stateQ == EXPAND) begin
         wordBuf[idxQ] <= newWord;
      end
   end

   always_comb begin
      roundKey = '0;
      if (stateQ == STREAM) begin
         roundKey = {wordBuf[rdBase], wordBuf[rdBase + AW'(1)],
                     wordBuf[rdBase + AW'(2)], wordBuf[rdBase + AW'(3)]};
      end
   end

   assign busy          = (stateQ != IDLE);
   assign roundKeyValid = (stateQ == STREAM);
   assign roundKeyLast  = (stateQ == STREAM) && (decQ ? (rndQ == 4'd0) : (rndQ == nr));
   assign done          = doneQ;
   assign keyError      = keyErrQ;

endmodule

// File: tb/tb_aes_key_schedule_streamer.sv
// Bench for aes_key_schedule_streamer: known-answer table plus randomized runs against a
// FIPS-197 style model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_schedule_streamer;

   logic         clk = 1'b0;
   logic         resetN = 1'b1;
   logic         start = 1'b0;
   logic         start6 = 1'b0;
   logic         abort = 1'b0;
   logic [7:0]   Nk = 8'd4;
   logic         decOrder = 1'b0;
   logic [255:0] cipherKey = '0;
   logic         roundKeyReady = 1'b0;
   logic         busy, roundKeyValid, roundKeyLast, done, keyError;
   logic [127:0] roundKey;
   logic         busy6, roundKeyValid6, roundKeyLast6, done6, keyError6;
   logic [127:0] roundKey6;

   int nChecks = 0;
   int nErrors = 0;

   logic [7:0]   refSbox [0:255];
   logic [31:0]  mw [0:59];
   logic [127:0] gotQ [$];

   typedef struct {
      logic [7:0]   nk;
      logic         dec;
      logic [255:0] key;
      logic [127:0] first;
      logic [127:0] last;
   } vec_t;
   vec_t vecs [3];

   always #5 clk = ~clk;

   aes_key_schedule_streamer #(.MAX_NK(8)) dut (
      .clk(clk), .resetN(resetN), .start(start), .abort(abort), .Nk(Nk),
      .decOrder(decOrder), .cipherKey(cipherKey), .busy(busy), .roundKey(roundKey),
      .roundKeyValid(roundKeyValid), .roundKeyReady(roundKeyReady),
      .roundKeyLast(roundKeyLast), .done(done), .keyError(keyError)
   );

   aes_key_schedule_streamer #(.MAX_NK(6)) dut6 (
      .clk(clk), .resetN(resetN), .start(start6), .abort(abort), .Nk(Nk),
      .decOrder(decOrder), .cipherKey(cipherKey), .busy(busy6), .roundKey(roundKey6),
      .roundKeyValid(roundKeyValid6), .roundKeyReady(roundKeyReady),
      .roundKeyLast(roundKeyLast6), .done(done6), .keyError(keyError6)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   task automatic buildSbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         refSbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] refSub(input logic [31:0] t);
      return {refSbox[t[31:24]], refSbox[t[23:16]], refSbox[t[15:8]], refSbox[t[7:0]]};
   endfunction

   task automatic modelExpand(input logic [255:0] key, input int nk);
      logic [7:0]  rc;
      logic [31:0] t;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) mw[i] = 32'(key >> (32 * (nk - 1 - i)));
      for (int i = nk; i < 4 * (nk + 7); i++) begin
         t = mw[i - 1];
         if (i % nk == 0) begin
            t = refSub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = refSub(t);
         end
         mw[i] = mw[i - nk] ^ t;
      end
   endtask

   task automatic startAndWait(input logic [7:0] nk, input logic dec, input logic [255:0] key,
                               output int cyc);
      Nk = nk; decOrder = dec; cipherKey = key; start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1;
      while (!roundKeyValid && cyc < 300) begin
         step();
         cyc++;
      end
   endtask

   // mode 0: ready held high; mode 1: random ready with long stalls and stray starts.
   task automatic runStream(input logic [7:0] nk, input logic dec, input logic [255:0] key,
                            input int mode);
      int nr;
      int cyc;
      int lim;
      int stallLeft;
      int r;
      bit seenLast;
      bit stalled;
      logic [127:0] prevKey;
      logic prevLast;
      logic [127:0] expQ [$];
      nr = int'(nk) + 6;
      modelExpand(key, int'(nk));
      for (int k = 0; k <= nr; k++) begin
         r = dec ? nr - k : k;
         expQ.push_back({mw[4 * r], mw[4 * r + 1], mw[4 * r + 2], mw[4 * r + 3]});
      end
      gotQ.delete();
      roundKeyReady = (mode == 0);
      startAndWait(nk, dec, key, cyc);
      check("first valid latency", 128'(cyc), 128'(2 + 4 * (int'(nk) + 7) - int'(nk)));
      seenLast = 0; stalled = 0; lim = 0; stallLeft = 0;
      prevKey = '0; prevLast = 1'b0;
      while (!seenLast && lim < 3000) begin
         if (!roundKeyValid) begin
            check("valid during stream", 128'(roundKeyValid), 128'(1));
            break;
         end
         if (stalled) begin
            check("stable key while stalled", roundKey, prevKey);
            check("stable last while stalled", 128'(roundKeyLast), 128'(prevLast));
         end
         check("last flag position", 128'(roundKeyLast), 128'(gotQ.size() == nr));
         check("no done while streaming", 128'(done), 128'(0));
         if (mode == 1) begin
            if (stallLeft > 0) begin
               roundKeyReady = 1'b0;
               stallLeft--;
            end else if ($urandom_range(0, 9) == 0) begin
               roundKeyReady = 1'b0;
               stallLeft = $urandom_range(5, 30);
            end else begin
               roundKeyReady = 1'($urandom_range(0, 1));
            end
            start = ($urandom_range(0, 5) == 0);
            Nk = 8'd4;
            decOrder = 1'($urandom);
            cipherKey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom};
         end
         if (roundKeyReady) begin
            gotQ.push_back(roundKey);
            seenLast = roundKeyLast;
         end
         stalled = !roundKeyReady;
         prevKey = roundKey;
         prevLast = roundKeyLast;
         step();
         lim++;
      end
      start = 1'b0;
      check("done after last", 128'(done), 128'(1));
      check("valid dropped after last", 128'(roundKeyValid), 128'(0));
      check("idle after last", 128'(busy), 128'(0));
      step();
      check("done is one cycle", 128'(done), 128'(0));
      check("transfer count", 128'(gotQ.size()), 128'(expQ.size()));
      for (int k = 0; k < expQ.size() && k < gotQ.size(); k++) begin
         check($sformatf("round key %0d", k), gotQ[k], expQ[k]);
      end
   endtask

   task automatic runVec(input int v);
      runStream(vecs[v].nk, vecs[v].dec, vecs[v].key, 0);
      check($sformatf("vec%0d first key", v), gotQ[0], vecs[v].first);
      check($sformatf("vec%0d last key", v), gotQ[gotQ.size() - 1], vecs[v].last);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      bit quiet;
      vecs[0] = '{nk: 8'd4, dec: 1'b0, key: 256'h000102030405060708090a0b0c0d0e0f,
                  first: 128'h000102030405060708090a0b0c0d0e0f,
                  last: 128'h13111d7fe3944a17f307a78b4d2b30c5};
      vecs[1] = '{nk: 8'd6, dec: 1'b1,
                  key: 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                  first: 128'he98ba06f448c773c8ecc720401002202,
                  last: 128'h8e73b0f7da0e6452c810f32b809079e5};
      vecs[2] = '{nk: 8'd8, dec: 1'b0,
                  key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                  first: 128'h603deb1015ca71be2b73aef0857d7781,
                  last: 128'hfe4890d1e6188d0b046df344706c631e};
      buildSbox();
      check("model sbox 00", 128'(refSbox[8'h00]), 128'(8'h63));
      check("model sbox 53", 128'(refSbox[8'h53]), 128'(8'hed));

      // Asynchronous reset before any clock edge.
      #2 resetN = 1'b0;
      #1;
      check("reset busy", 128'(busy), 128'(0));
      check("reset valid", 128'(roundKeyValid), 128'(0));
      check("reset last", 128'(roundKeyLast), 128'(0));
      check("reset done", 128'(done), 128'(0));
      check("reset keyError", 128'(keyError), 128'(0));
      check("reset roundKey", roundKey, 128'h0);
      step(); step();
      resetN = 1'b1;
      step();

      for (int v = 0; v < 3; v++) runVec(v);

      // Illegal key lengths.
      Nk = 8'd5; start = 1'b1;
      step();
      start = 1'b0;
      check("Nk=5 keyError", 128'(keyError), 128'(1));
      check("Nk=5 busy", 128'(busy), 128'(0));
      check("Nk=5 valid", 128'(roundKeyValid), 128'(0));
      step();
      check("keyError one cycle", 128'(keyError), 128'(0));
      check("Nk=5 still idle", 128'(busy), 128'(0));
      Nk = 8'd8; start6 = 1'b1;
      step();
      start6 = 1'b0;
      check("MAX_NK=6 Nk=8 keyError", 128'(keyError6), 128'(1));
      check("MAX_NK=6 Nk=8 busy", 128'(busy6), 128'(0));
      Nk = 8'd6; start6 = 1'b1;
      step();
      start6 = 1'b0;
      check("MAX_NK=6 Nk=6 no keyError", 128'(keyError6), 128'(0));
      check("MAX_NK=6 Nk=6 busy", 128'(busy6), 128'(1));
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("MAX_NK=6 abort", 128'(busy6), 128'(0));

      // abort and start together in IDLE: abort wins.
      Nk = 8'd4; start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("abort beats start", 128'(busy), 128'(0));

      // abort during EXPAND.
      Nk = 8'd4; decOrder = 1'b0; cipherKey = vecs[0].key; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 10; k++) step();
      check("busy in expand", 128'(busy), 128'(1));
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort expand valid", 128'(roundKeyValid), 128'(0));
      check("abort expand busy", 128'(busy), 128'(0));
      quiet = 1;
      for (int k = 0; k < 60; k++) begin
         if (roundKeyValid || done || busy) quiet = 0;
         step();
      end
      check("quiet after abort", 128'(quiet), 128'(1));
      runVec(0);

      // abort during STREAM.
      roundKeyReady = 1'b0;
      startAndWait(8'd4, 1'b0, vecs[0].key, cyc);
      check("valid before stream abort", 128'(roundKeyValid), 128'(1));
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort stream valid", 128'(roundKeyValid), 128'(0));
      check("abort stream done", 128'(done), 128'(0));

      // Reset in the middle of a stream.
      startAndWait(8'd4, 1'b0, vecs[0].key, cyc);
      roundKeyReady = 1'b1;
      for (int k = 0; k < 3; k++) step();
      roundKeyReady = 1'b0;
      check("still streaming before reset", 128'(roundKeyValid), 128'(1));
      resetN = 1'b0;
      #1;
      check("reset mid-stream valid", 128'(roundKeyValid), 128'(0));
      check("reset mid-stream busy", 128'(busy), 128'(0));
      check("reset mid-stream key", roundKey, 128'h0);
      check("reset mid-stream last", 128'(roundKeyLast), 128'(0));
      step();
      check("reset mid-stream done", 128'(done), 128'(0));
      resetN = 1'b1;
      step();
      runVec(0);

      // Fixed Nk=8 vector with random backpressure, then random keys.
      runStream(vecs[2].nk, vecs[2].dec, vecs[2].key, 1);
      check("stalled Nk=8 last key", gotQ[gotQ.size() - 1], vecs[2].last);
      for (int n = 0; n < 12; n++) begin
         logic [7:0] nk;
         nk = 8'(4 + 2 * $urandom_range(0, 2));
         runStream(nk, 1'($urandom),
                   {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom}, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
